// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges ALU and buffered LSU results onto the single register file write port
// Also keeps a per-register busy scoreboard for outstanding loads.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_issue,
    input  logic [4:0]      lsu_issue_rd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            RegWEn,
    output logic [4:0]      AddrD,
    output logic [XLEN-1:0] DataD,
    output logic [31:0]     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            reg_wen_q, reg_wen_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [31:0]     busy_q, busy_d;

    logic            full, empty;
    logic            push, pop, alu_take;
    logic [4:0]      head_rd, sel_rd;
    logic [XLEN-1:0] head_data, sel_data;
    logic [31:0]     set_mask, clr_mask;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign alu_ready = !full;
    assign lsu_ready = !full;

    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // A full FIFO pre-empts the ALU so buffered loads can never starve.
    assign push     = lsu_valid && !full;
    assign alu_take = alu_valid && !full;
    assign pop      = full || (!alu_valid && !empty);

    always_comb begin
        sel_rd   = alu_take ? alu_rd : head_rd;
        sel_data = alu_take ? alu_data : head_data;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        reg_wen_d = (alu_take || pop) && (sel_rd != 5'd0);
        addr_d    = addr_q;
        data_d    = data_q;
        if (alu_take || pop) begin
            addr_d = sel_rd;
            data_d = sel_data;
        end

        // Set after clear: a same-cycle issue is a newer load to that register.
        set_mask = lsu_issue ? (32'd1 << lsu_issue_rd) : 32'd0;
        clr_mask = pop ? (32'd1 << head_rd) : 32'd0;
        busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            reg_wen_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            reg_wen_q <= reg_wen_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= lsu_rd;
            fifo_data_q[wr_ptr_q] <= lsu_data;
        end
    end

    assign RegWEn = reg_wen_q;
    assign AddrD  = addr_q;
    assign DataD  = data_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed scoreboard bench for regfile_writeback
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_issue;
    logic [4:0]  lsu_issue_rd;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        RegWEn;
    logic [4:0]  AddrD;
    logic [31:0] DataD;
    logic [31:0] busy;

    int n_vec  = 0;
    int n_fail = 0;
    logic [36:0] exp_q[$];

    regfile_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every register file write must match the next expected write.
    always @(negedge clk) begin
        if (RegWEn === 1'b1) begin
            logic [36:0] e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", AddrD, DataD);
            end else begin
                e = exp_q.pop_front();
                if ({AddrD, DataD} !== e) begin
                    n_fail++;
                    $display("FAIL write_seq: got rd=%0d data=%h, expected rd=%0d data=%h",
                             AddrD, DataD, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd);
        lsu_issue = v; lsu_issue_rd = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        alu(0, 0, 0); lsu(0, 0, 0); issue(0, 0);
        tick; tick;
        rst_n = 1'b1;
        #1;
        chk("reset_regwen", {31'd0, RegWEn}, 32'd0);
        chk("reset_addr", {27'd0, AddrD}, 32'd0);
        chk("reset_data", DataD, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);

        // ALU only
        alu(1, 5, 32'h0000_00AA); expect_wr(5, 32'hAA);
        tick;
        alu(0, 0, 0);
        chk("alu_wen", {31'd0, RegWEn}, 32'd1);
        chk("alu_addr", {27'd0, AddrD}, 32'd5);
        tick;
        chk("alu_wen_drop", {31'd0, RegWEn}, 32'd0);

        // LSU path and busy
        issue(1, 7);
        tick;
        issue(0, 0);
        chk("busy7_set", {31'd0, busy[7]}, 32'd1);
        tick; tick;
        lsu(1, 7, 32'h1234); expect_wr(7, 32'h1234);
        tick;
        lsu(0, 0, 0);
        chk("busy7_held", {31'd0, busy[7]}, 32'd1);
        chk("lsu_no_early_wr", {31'd0, RegWEn}, 32'd0);
        tick;
        chk("lsu_wen", {31'd0, RegWEn}, 32'd1);
        chk("lsu_addr", {27'd0, AddrD}, 32'd7);
        chk("busy7_clear", {31'd0, busy[7]}, 32'd0);

        // Priority and FIFO fill
        alu(1, 10, 32'hA0); lsu(1, 1, 32'h101); expect_wr(10, 32'hA0); tick;
        alu(1, 11, 32'hA1); lsu(1, 2, 32'h102); expect_wr(11, 32'hA1); tick;
        alu(1, 12, 32'hA2); lsu(1, 3, 32'h103); expect_wr(12, 32'hA2); tick;
        alu(1, 13, 32'hA3); lsu(1, 4, 32'h104); expect_wr(13, 32'hA3);
        #1 chk("ready_at_3", {30'd0, alu_ready, lsu_ready}, 32'd3);
        tick;
        alu(1, 14, 32'hA4); lsu(0, 0, 0);
        #1 chk("full_stall", {30'd0, alu_ready, lsu_ready}, 32'd0);
        expect_wr(1, 32'h101); expect_wr(14, 32'hA4);
        tick;
        chk("ready_after_pop", {30'd0, alu_ready, lsu_ready}, 32'd3);
        tick;
        alu(1, 15, 32'hA5); expect_wr(15, 32'hA5); tick;
        alu(0, 0, 0);
        expect_wr(2, 32'h102); expect_wr(3, 32'h103); expect_wr(4, 32'h104);
        tick; tick; tick; tick;

        // rd = 0 handling
        alu(1, 0, 32'hFFFF_FFFF); tick;
        alu(0, 0, 0);
        chk("alu_rd0_wen", {31'd0, RegWEn}, 32'd0);
        lsu(1, 0, 32'h55); issue(1, 0); tick;
        lsu(0, 0, 0); issue(0, 0);
        chk("busy_rd0", busy, 32'd0);
        tick;
        chk("lsu_rd0_wen", {31'd0, RegWEn}, 32'd0);
        alu(1, 24, 32'h124); lsu(1, 21, 32'h121); expect_wr(24, 32'h124); tick;
        alu(1, 25, 32'h125); lsu(1, 22, 32'h122); expect_wr(25, 32'h125); tick;
        alu(1, 26, 32'h126); lsu(1, 23, 32'h123); expect_wr(26, 32'h126); tick;
        alu(0, 0, 0); lsu(0, 0, 0);
        chk("rd0_consumed", {30'd0, alu_ready, lsu_ready}, 32'd3);
        expect_wr(21, 32'h121); expect_wr(22, 32'h122); expect_wr(23, 32'h123);
        tick; tick; tick; tick;

        // Set/clear collision
        issue(1, 9); tick;
        issue(0, 0); lsu(1, 9, 32'h99); expect_wr(9, 32'h99); tick;
        lsu(0, 0, 0); issue(1, 9); tick;
        issue(0, 0);
        chk("collision_wen", {27'd0, AddrD}, 32'd9);
        chk("collision_busy9", {31'd0, busy[9]}, 32'd1);

        // Reset mid-operation
        issue(1, 7); alu(1, 27, 32'h127); lsu(1, 11, 32'h111); expect_wr(27, 32'h127); tick;
        issue(1, 8); alu(1, 28, 32'h128); lsu(1, 12, 32'h112); expect_wr(28, 32'h128); tick;
        issue(0, 0); alu(1, 29, 32'h129); lsu(1, 13, 32'h113); expect_wr(29, 32'h129); tick;
        alu(0, 0, 0); lsu(0, 0, 0); rst_n = 1'b0;
        chk("busy_pre_reset", busy, 32'h0000_0380);
        tick;
        rst_n = 1'b1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_wen", {31'd0, RegWEn}, 32'd0);
        chk("rst_addr", {27'd0, AddrD}, 32'd0);
        chk("rst_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);
        repeat (6) tick;
        chk("no_stale_wen", {31'd0, RegWEn}, 32'd0);
        chk("exp_queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback sequencer driving the single write port of the 32×32 register file. It merges single-cycle ALU results with variable-latency load/store-unit (LSU) results into one write per cycle. LSU results are buffered in a small FIFO, and a per-register busy scoreboard is kept for hazard detection in decode. It sits between the execute/LSU stages and the register file write port (RegWEn/AddrD/DataD).

## Interface
Parameters:
- DEPTH, 4: LSU result FIFO entries; power of two, ≥2.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result accepted; the ALU holds its result while this is low.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_issue  in  1  a load to lsu_issue_rd entered the LSU; marks the register busy.
- lsu_issue_rd  in  5  destination of the issued load.
- lsu_valid  in  1  LSU result present.
- lsu_ready  out  1  LSU result accepted (FIFO not full).
- lsu_rd  in  5  LSU result destination.
- lsu_data  in  XLEN  LSU result.
- RegWEn  out  1  register file write enable (registered).
- AddrD  out  5  register file write address (registered).
- DataD  out  XLEN  register file write data (registered).
- busy  out  32  scoreboard; bit i high means a load to xi is outstanding. Bit 0 is always 0.

## Operation
- **FIFO.**
  - A push occurs on lsu_valid && lsu_ready.
  - lsu_ready = !full. It is computed from the current occupancy count, not from the same-cycle pop.
  - Occupancy counter is clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **ALU acceptance.** alu_ready = !full.
- **Per-cycle write selection.** At most one source is chosen per cycle:
  1. If the FIFO is full: pop the head. The ALU is not accepted.
  2. Else if alu_valid: write the ALU result.
  3. Else if the FIFO is not empty: pop the head.
  4. Else: no write.
- **Write-port registers.** The selected (rd, data) is registered into AddrD/DataD.
  - RegWEn is registered as 1 only when a source was selected and its rd ≠ 0.
  - A selected entry with rd = 0 is consumed silently: RegWEn = 0.
  - When nothing is selected, AddrD/DataD hold their previous values and RegWEn = 0.
- **Scoreboard.**
  - lsu_issue with lsu_issue_rd ≠ 0 sets busy[rd].
  - A FIFO pop of rd clears busy[rd].
  - If the same rd is set and cleared in the same cycle, set wins: it represents a newer outstanding load.
  - An ALU write does not touch busy.
- **Ordering.** LSU results retire in arrival order. No ordering is guaranteed between the ALU and LSU paths; decode uses busy to avoid WAW hazards.

## Timing
- **Reset** (rst_n = 0 at an edge) forces:
  - RegWEn = 0, AddrD = 0, DataD = 0, busy = 0.
  - FIFO empty: count = 0, pointers = 0.
  - After the edge, alu_ready = 1 and lsu_ready = 1.
  - Reset mid-operation discards buffered LSU results and all busy bits.
- **ALU latency.** alu_valid && alu_ready in cycle N → RegWEn/AddrD/DataD valid in cycle N+1.
- **LSU latency.** Push in cycle N → entry visible in cycle N+1 → earliest RegWEn in cycle N+2. Each cycle of continuous ALU traffic adds one cycle, until the FIFO fills.
- **Full condition.**
  - Full in cycle N: the head pops, and alu_ready = lsu_ready = 0 in cycle N.
  - Occupancy drops to DEPTH−1 at the N+1 edge, so ready rises in cycle N+1.
  - A full FIFO therefore costs the ALU exactly one stall cycle per pop-from-full.
- **Busy timing.**
  - A bit set by lsu_issue in cycle N is visible from cycle N+1.
  - A bit cleared by a pop in cycle N goes low in cycle N+1, the same cycle RegWEn is high for that write.
- **Simultaneous push and pop** on a non-full FIFO leaves occupancy unchanged.

## Test plan
- **ALU only.** After reset, alu_valid = 1, rd = 5, data = 0x0000_00AA for one cycle → next cycle RegWEn = 1, AddrD = 5, DataD = 0xAA. The following cycle RegWEn = 0.
- **LSU path and busy.** lsu_issue rd = 7 in cycle 0 → busy[7] = 1 from cycle 1. lsu_valid rd = 7, data = 0x1234 in cycle 3 (no ALU traffic) → RegWEn = 1, AddrD = 7 in cycle 5; busy[7] = 0 in cycle 5.
- **Priority and FIFO fill (DEPTH = 4).** Hold alu_valid = 1 continuously and push 4 LSU results with rd 1, 2, 3, 4 →
  - lsu_ready = 0 once count = 4.
  - The next cycle pops rd 1 with alu_ready = 0 (ALU result held).
  - The write sequence shows the ALU, then x1, then ALU writes resume.
- **rd = 0.** ALU rd = 0, data = 0xFFFF_FFFF → RegWEn stays 0. LSU entry with rd = 0 → consumed (count decrements) with RegWEn = 0. lsu_issue rd = 0 → busy[0] stays 0.
- **Set/clear collision.** A pop of rd = 9 in the same cycle as lsu_issue rd = 9 → busy[9] = 1 afterward.
- **Reset mid-operation.** With 3 FIFO entries and busy = 0x0000_0380, assert rst_n = 0 for one edge → count = 0, busy = 0, RegWEn = 0. No stale entry is written afterward.
